// File: rtl/ieeedrv_sdhost.sv
// SD-side block responder for the IEEE drive: round-robin grant of sd_rd/sd_wr, byte streaming
// between the drive buffer bus and a byte-wide image memory. Define IEEEDRV_SDHOST_IMGSIZE_EN for image bounds checking.
module ieeedrv_sdhost #(
   parameter int SUBDRV    = 2,
   parameter int SECT_BITS = 8
) (
   input  logic                     clk_sys,
   input  logic                     reset_n,
   input  logic [SUBDRV-1:0][31:0]  sd_lba,
   input  logic [SUBDRV-1:0][5:0]   sd_blk_cnt,
   input  logic [SUBDRV-1:0]        sd_rd,
   input  logic [SUBDRV-1:0]        sd_wr,
   output logic [SUBDRV-1:0]        sd_ack,
   output logic [12:0]              sd_buff_addr,
   output logic [7:0]               sd_buff_dout,
   input  logic [SUBDRV-1:0][7:0]   sd_buff_din,
   output logic                     sd_buff_wr,
   input  logic [SUBDRV-1:0]        img_readonly,
`ifdef IEEEDRV_SDHOST_IMGSIZE_EN
   input  logic [SUBDRV-1:0][31:0]  img_size,
`endif
   output logic [31:0]              mem_addr,
   output logic                     mem_rd,
   output logic                     mem_wr,
   output logic [7:0]               mem_din,
   input  logic [7:0]               mem_dout,
   input  logic                     mem_ready,
   output logic                     wr_err
);

   localparam int NS   = SUBDRV - 1;
   localparam int SELW = (SUBDRV > 1) ? $clog2(SUBDRV) : 1;
   // one extra bit so a full 64-block transfer end (cnt<<8) is representable
   localparam int OFFW = SECT_BITS + 7;

   typedef enum logic [2:0] {IDLE, RD_REQ, RD_PUT, WR_ADDR, WR_REQ, DONE} state_t;

   state_t              state_reg, state_next;
   logic [SELW-1:0]     sel_reg, ptr_reg;
   logic [31:0]         lba_reg;
   logic [6:0]          cnt_reg;
   logic [OFFW-2:0]     offset_reg;
   logic [7:0]          data_reg;
   logic                err_reg;

   logic                req_found;
   logic [SELW-1:0]     req_idx;
   logic [OFFW-1:0]     off_inc;
   logic                last_byte;
   logic                oob;
   logic                wr_drop;
   logic                ack_active;

   assign mem_addr  = (lba_reg << SECT_BITS) + 32'(offset_reg);
   assign off_inc   = {1'b0, offset_reg} + OFFW'(1);
   assign last_byte = (off_inc == (OFFW'(cnt_reg) << SECT_BITS));
`ifdef IEEEDRV_SDHOST_IMGSIZE_EN
   assign oob = (mem_addr >= img_size[sel_reg]);
`else
   assign oob = 1'b0;
`endif
   assign wr_drop = img_readonly[sel_reg] | oob;

   // Round-robin scan starting at the pointer; read beats write on the same subdrive.
   always_comb begin
      int j;
      req_found = 1'b0;
      req_idx   = '0;
      j         = 0;
      for (int k = 0; k < SUBDRV; k++) begin
         j = int'(ptr_reg) + k;
         if (j >= SUBDRV) j = j - SUBDRV;
         if (!req_found && (sd_rd[j] || sd_wr[j])) begin
            req_found = 1'b1;
            req_idx   = SELW'(j);
         end
      end
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) state_reg <= IDLE;
      else          state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      unique case (state_reg)
         IDLE:    if (req_found) state_next = sd_rd[req_idx] ? RD_REQ : WR_ADDR;
         RD_REQ:  if (oob || mem_ready) state_next = RD_PUT;
         RD_PUT:  state_next = last_byte ? DONE : RD_REQ;
         WR_ADDR: state_next = WR_REQ;
         WR_REQ:  if (wr_drop || mem_ready) state_next = last_byte ? DONE : WR_ADDR;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         sel_reg    <= '0;
         ptr_reg    <= '0;
         lba_reg    <= '0;
         cnt_reg    <= '0;
         offset_reg <= '0;
         data_reg   <= '0;
         err_reg    <= 1'b0;
      end else begin
         unique case (state_reg)
            IDLE: if (req_found) begin
               sel_reg    <= req_idx;
               lba_reg    <= sd_lba[req_idx];
               cnt_reg    <= 7'(sd_blk_cnt[req_idx]) + 7'd1;
               offset_reg <= '0;
               err_reg    <= 1'b0;
               ptr_reg    <= (req_idx == SELW'(NS)) ? '0 : req_idx + SELW'(1);
            end
            RD_REQ: begin
               if (oob)            data_reg <= 8'h00;
               else if (mem_ready) data_reg <= mem_dout;
            end
            RD_PUT: offset_reg <= off_inc[OFFW-2:0];
            WR_REQ: if (wr_drop || mem_ready) begin
               offset_reg <= off_inc[OFFW-2:0];
               if (wr_drop) err_reg <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      ack_active   = (state_reg == RD_REQ) || (state_reg == RD_PUT) ||
                     (state_reg == WR_ADDR) || (state_reg == WR_REQ);
      sd_buff_addr = offset_reg[12:0];
      sd_buff_dout = data_reg;
      sd_buff_wr   = (state_reg == RD_PUT);
      mem_rd       = (state_reg == RD_REQ) && !oob;
      mem_wr       = (state_reg == WR_REQ) && !wr_drop;
      // buffer address is held through WR_REQ, so the drive's registered data stays valid
      mem_din      = (state_reg == WR_REQ) ? sd_buff_din[sel_reg] : 8'h00;
      wr_err       = (state_reg == DONE) && err_reg;
   end

   generate
      for (genvar gi = 0; gi < SUBDRV; gi++) begin : g_ack
         assign sd_ack[gi] = ack_active && (sel_reg == SELW'(gi));
      end
   endgenerate

endmodule

// File: tb/tb_ieeedrv_sdhost.sv
// Scoreboard bench for ieeedrv_sdhost: memory model with 2-cycle latency, registered drive buffer model.
module tb_ieeedrv_sdhost;
   localparam int SUBDRV = 2;

   logic                    clk_sys = 1'b0;
   logic                    reset_n;
   logic [SUBDRV-1:0][31:0] sd_lba;
   logic [SUBDRV-1:0][5:0]  sd_blk_cnt;
   logic [SUBDRV-1:0]       sd_rd, sd_wr, sd_ack, img_readonly;
   logic [12:0]             sd_buff_addr;
   logic [7:0]              sd_buff_dout;
   logic [SUBDRV-1:0][7:0]  buf_din;
   logic                    sd_buff_wr;
`ifdef IEEEDRV_SDHOST_IMGSIZE_EN
   logic [SUBDRV-1:0][31:0] img_size;
`endif
   logic [31:0]             mem_addr;
   logic                    mem_rd, mem_wr, mem_ready, wr_err;
   logic [7:0]              mem_din, mem_dout;

   int n_cmp = 0;
   int n_err = 0;
   int lat;
   int err_pulses, mem_wr_cycles, mem_rd_cycles, addr_steps;

   logic [22:0] put_q[$];   // {ack, buff_addr, dout}
   logic [31:0] rda_q[$];   // memory read addresses
   logic [41:0] wr_q[$];    // {ack, mem_addr, mem_din}

   always #5 clk_sys = ~clk_sys;

   ieeedrv_sdhost #(.SUBDRV(SUBDRV), .SECT_BITS(8)) dut (
      .clk_sys(clk_sys), .reset_n(reset_n), .sd_lba(sd_lba), .sd_blk_cnt(sd_blk_cnt),
      .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack), .sd_buff_addr(sd_buff_addr),
      .sd_buff_dout(sd_buff_dout), .sd_buff_din(buf_din), .sd_buff_wr(sd_buff_wr),
      .img_readonly(img_readonly),
`ifdef IEEEDRV_SDHOST_IMGSIZE_EN
      .img_size(img_size),
`endif
      .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_din(mem_din),
      .mem_dout(mem_dout), .mem_ready(mem_ready), .wr_err(wr_err));

   // image memory: returns addr[7:0], ready two cycles after a request appears
   always @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         mem_ready <= 1'b0;
         mem_dout  <= 8'h00;
         lat       <= 0;
      end else begin
         mem_ready <= 1'b0;
         if ((mem_rd || mem_wr) && !mem_ready) begin
            if (lat == 1) begin
               mem_ready <= 1'b1;
               mem_dout  <= mem_addr[7:0];
               lat       <= 0;
            end else lat <= lat + 1;
         end else lat <= 0;
      end
   end

   // drive track buffer: one-cycle registered read
   always @(posedge clk_sys) begin
      buf_din[0] <= sd_buff_addr[7:0] ^ 8'h5A;
      buf_din[1] <= ~sd_buff_addr[7:0];
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
      end
   endtask

   initial begin
      logic [12:0] prev_addr;
      bit          have_prev;
      logic [22:0] pe;
      logic [31:0] ra;
      logic [41:0] we;
      have_prev = 1'b0;
      prev_addr = '0;
      forever begin
         @(negedge clk_sys);
         if (reset_n) begin
            if (sd_buff_wr) begin
               check("put_pending", 64'(put_q.size() != 0), 64'd1);
               if (put_q.size() != 0) begin
                  pe = put_q.pop_front();
                  check("put", {sd_ack, sd_buff_addr, sd_buff_dout}, 64'(pe));
               end
            end
            if (mem_rd && mem_ready) begin
               check("rd_pending", 64'(rda_q.size() != 0), 64'd1);
               if (rda_q.size() != 0) begin
                  ra = rda_q.pop_front();
                  check("rd_addr", mem_addr, 64'(ra));
               end
            end
            if (mem_wr && mem_ready) begin
               check("wr_pending", 64'(wr_q.size() != 0), 64'd1);
               if (wr_q.size() != 0) begin
                  we = wr_q.pop_front();
                  check("wr", {sd_ack, mem_addr, mem_din}, 64'(we));
               end
            end
            if (wr_err) begin
               err_pulses++;
               check("wr_err_ack", 64'(sd_ack), 64'd0);
            end
            if (mem_wr) mem_wr_cycles++;
            if (mem_rd) mem_rd_cycles++;
            if (sd_ack != 0) begin
               if (have_prev && sd_buff_addr == prev_addr + 13'd1) addr_steps++;
               prev_addr = sd_buff_addr;
               have_prev = 1'b1;
            end else have_prev = 1'b0;
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk_sys);
   endtask

   task automatic expect_read(input int sd, input logic [31:0] lba, input int blk, input bit zero);
      logic [31:0] a;
      logic [1:0]  ack;
      ack = 2'(1 << sd);
      for (int i = 0; i < (blk + 1) * 256; i++) begin
         a = (lba << 8) + 32'(i);
         if (!zero) rda_q.push_back(a);
         put_q.push_back({ack, 13'(i), zero ? 8'h00 : a[7:0]});
      end
   endtask

   task automatic expect_write(input int sd, input logic [31:0] lba, input int blk);
      logic [31:0] a;
      logic [7:0]  iv, d;
      logic [1:0]  ack;
      ack = 2'(1 << sd);
      for (int i = 0; i < (blk + 1) * 256; i++) begin
         a  = (lba << 8) + 32'(i);
         iv = 8'(i);
         d  = (sd == 1) ? ~iv : (iv ^ 8'h5A);
         wr_q.push_back({ack, a, d});
      end
   endtask

   // wait for an ack, then drop that subdrive's request
   task automatic grab(output int g, output int waited);
      int n;
      n = 0;
      while (sd_ack == 0 && n < 4000) begin
         @(negedge clk_sys);
         n++;
      end
      check("ack_rise", 64'(sd_ack != 0), 64'd1);
      g = sd_ack[1] ? 1 : 0;
      $display("grant sd%0d rd=%0b wr=%0b lba=%0h at %0t", g, sd_rd[g], sd_wr[g], sd_lba[g], $time);
      sd_rd  = sd_rd & ~sd_ack;
      sd_wr  = sd_wr & ~sd_ack;
      waited = n;
   endtask

   task automatic wait_low();
      int n;
      n = 0;
      while (sd_ack != 0 && n < 6000) begin
         @(negedge clk_sys);
         n++;
      end
      check("ack_fall", 64'(sd_ack), 64'd0);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((sd_ack != 0 || put_q.size() != 0 || rda_q.size() != 0 || wr_q.size() != 0) && n < 6000) begin
         @(negedge clk_sys);
         n++;
      end
      tick(2);
      check("drain", 64'(put_q.size() + rda_q.size() + wr_q.size()), 64'd0);
      check("ack_idle", 64'(sd_ack), 64'd0);
   endtask

   initial begin
      int g, w;
      #1_500_000;
      $display("FAIL watchdog: observed timeout, expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int g, w;
      reset_n = 1'b0;
      sd_lba = '0; sd_blk_cnt = '0; sd_rd = '0; sd_wr = '0; img_readonly = '0;
`ifdef IEEEDRV_SDHOST_IMGSIZE_EN
      img_size = {32'hFFFF_FFFF, 32'hFFFF_FFFF};
`endif
      err_pulses = 0; mem_wr_cycles = 0; mem_rd_cycles = 0; addr_steps = 0;
      tick(3);
      check("rst_ack", 64'(sd_ack), 64'd0);
      check("rst_mem", {mem_rd, mem_wr, sd_buff_wr, wr_err}, 64'd0);
      check("rst_addr", {mem_addr, sd_buff_addr}, 64'd0);
      reset_n = 1'b1;
      tick(2);

      // single-block read, subdrive 0
      sd_lba[0] = 32'd357;
      expect_read(0, 32'd357, 0, 1'b0);
      sd_rd[0] = 1'b1;
      grab(g, w);
      check("t1_grant", 64'(g), 64'd0);
      wait_idle();

      // two-block write, subdrive 1
      sd_lba[1] = 32'd2; sd_blk_cnt[1] = 6'd1;
      expect_write(1, 32'd2, 1);
      sd_wr[1] = 1'b1;
      grab(g, w);
      check("t2_grant", 64'(g), 64'd1);
      wait_idle();
      check("t2_no_err", 64'(err_pulses), 64'd0);
      sd_blk_cnt[1] = 6'd0;

      // simultaneous reads, pointer at 0
      sd_lba[0] = 32'd10; sd_lba[1] = 32'd20;
      expect_read(0, 32'd10, 0, 1'b0);
      expect_read(1, 32'd20, 0, 1'b0);
      sd_rd = 2'b11;
      grab(g, w);
      check("pairA_first", 64'(g), 64'd0);
      wait_low();
      grab(g, w);
      check("pairA_second", 64'(g), 64'd1);
      check("pairA_gap", 64'(w >= 1), 64'd1);
      wait_idle();

      // write to read-only image, subdrive 0
      img_readonly[0] = 1'b1;
      sd_lba[0] = 32'd3;
      err_pulses = 0; mem_wr_cycles = 0; addr_steps = 0;
      sd_wr[0] = 1'b1;
      grab(g, w);
      check("ro_grant", 64'(g), 64'd0);
      wait_idle();
      check("ro_mem_wr", 64'(mem_wr_cycles), 64'd0);
      check("ro_err_pulses", 64'(err_pulses), 64'd1);
      check("ro_addr_steps", 64'(addr_steps), 64'd255);
      img_readonly[0] = 1'b0;

      // simultaneous reads, pointer now at 1
      sd_lba[0] = 32'd40; sd_lba[1] = 32'd50;
      expect_read(1, 32'd50, 0, 1'b0);
      expect_read(0, 32'd40, 0, 1'b0);
      sd_rd = 2'b11;
      grab(g, w);
      check("pairB_first", 64'(g), 64'd1);
      wait_low();
      grab(g, w);
      check("pairB_second", 64'(g), 64'd0);
      wait_idle();

      // reset in the middle of a read
      sd_lba[0] = 32'd0;
      expect_read(0, 32'd0, 0, 1'b0);
      sd_rd[0] = 1'b1;
      grab(g, w);
      w = 0;
      while (put_q.size() > 156 && w < 4000) begin
         @(negedge clk_sys);
         w++;
      end
      check("mid_progress", 64'(put_q.size() <= 156), 64'd1);
      #2 reset_n = 1'b0;
      #1;
      check("mid_rst_ack", 64'(sd_ack), 64'd0);
      check("mid_rst_mem", {mem_rd, mem_wr, sd_buff_wr}, 64'd0);
      put_q.delete(); rda_q.delete(); wr_q.delete();
      tick(3);
      reset_n = 1'b1;
      tick(1);
      sd_lba[1] = 32'd5;
      expect_read(1, 32'd5, 0, 1'b0);
      sd_rd[1] = 1'b1;
      grab(g, w);
      check("post_rst_grant", 64'(g), 64'd1);
      wait_idle();

`ifdef IEEEDRV_SDHOST_IMGSIZE_EN
      // read beyond the image end returns zeros without memory access
      img_size[0] = 32'h100;
      sd_lba[0] = 32'd1;
      mem_rd_cycles = 0;
      expect_read(0, 32'd1, 0, 1'b1);
      sd_rd[0] = 1'b1;
      grab(g, w);
      wait_idle();
      check("oob_mem_rd", 64'(mem_rd_cycles), 64'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
